// File: rtl/cnt_typedef_pkg.sv
// Shared counter types. The RTL and the environment's predictor both use these,
// so both apply the same state-transition rules.
package cnt_typedef_pkg;

  localparam int CNT_STATE_W = 3;

  typedef enum logic [CNT_STATE_W-1:0] {
    RESET   = 3'd0,
    INITIAL = 3'd1,
    LOAD    = 3'd2,
    UPCNT   = 3'd3,
    DWNCNT  = 3'd4,
    PREV    = 3'd5
  } cnt_state_e;

  typedef enum logic {
    DUT1 = 1'b0,
    DUT2 = 1'b1
  } cnt_dut_e;

  // Load outranks up/down. Simultaneous up and down counts as a real (null) operation,
  // so it leaves the idle states and reports PREV.
  function automatic cnt_state_e cnt_next_state(cnt_state_e cur, logic en, logic load,
                                                logic up, logic dwn);
    cnt_state_e idle_state;
    idle_state = (cur == RESET || cur == INITIAL) ? INITIAL : PREV;
    if (!en)              return idle_state;
    else if (load)        return LOAD;
    else if (up && !dwn)  return UPCNT;
    else if (dwn && !up)  return DWNCNT;
    else if (up && dwn)   return PREV;
    else                  return idle_state;
  endfunction

endpackage

// File: rtl/cnt_updown_core_if.sv
// Command and status bundle of the up/down counter.
// The driver takes the master modport and the counter takes the slave modport.
interface cnt_updown_core_if
  import cnt_typedef_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic             en_i;
  logic             load_i;
  logic             up_i;
  logic             dwn_i;
  logic [WIDTH-1:0] load_data_i;
  logic [WIDTH-1:0] count_o;
  cnt_state_e       state_o;
  logic             ovf_o;
  logic             unf_o;
  logic             tc_o;

  modport master (
    output en_i, load_i, up_i, dwn_i, load_data_i,
    input  count_o, state_o, ovf_o, unf_o, tc_o
  );

  modport slave (
    input  en_i, load_i, up_i, dwn_i, load_data_i,
    output count_o, state_o, ovf_o, unf_o, tc_o
  );

endinterface

// File: rtl/cnt_updown_arith.sv
// Combinational next-value logic for the counter. It works in WIDTH+1 bits, so the
// carry or borrow provides ovf/unf. DUT2 saturates at the limits; DUT1 wraps.
module cnt_updown_arith
  import cnt_typedef_pkg::*;
#(
  parameter int       WIDTH   = 8,
  parameter cnt_dut_e DUT_SEL = DUT1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf,
  output logic             unf
);

  localparam bit SAT = (DUT_SEL == DUT2);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, count} + (WIDTH+1)'(1);
  assign diff = {1'b0, count} - (WIDTH+1)'(1);

  always_comb begin
    next_count = count;
    ovf        = 1'b0;
    unf        = 1'b0;
    if (inc && !dec) begin
      ovf        = sum[WIDTH];
      next_count = (sum[WIDTH] && SAT) ? count : sum[WIDTH-1:0];
    end else if (dec && !inc) begin
      unf        = diff[WIDTH];
      next_count = (diff[WIDTH] && SAT) ? count : diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/cnt_updown_core.sv
// Loadable up/down counter. The wrap or saturate behaviour is chosen by DUT_SEL.
// The counter reports the state of its last operation as a cnt_state_e.
module cnt_updown_core
  import cnt_typedef_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter cnt_dut_e         DUT_SEL = DUT1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  cnt_updown_core_if.slave   bus
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  cnt_state_e       state_reg;
  logic             ovf_reg;
  logic             unf_reg;

  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] arith_next;
  logic             arith_ovf;
  logic             arith_unf;

  // Load masks up/down, so the arithmetic only sees qualified, load-free commands.
  assign inc = bus.en_i & ~bus.load_i & bus.up_i  & ~bus.dwn_i;
  assign dec = bus.en_i & ~bus.load_i & bus.dwn_i & ~bus.up_i;

  cnt_updown_arith #(
    .WIDTH   (WIDTH),
    .DUT_SEL (DUT_SEL)
  ) u_arith (
    .count      (count_reg),
    .inc        (inc),
    .dec        (dec),
    .next_count (arith_next),
    .ovf        (arith_ovf),
    .unf        (arith_unf)
  );

  assign count_next = (bus.en_i && bus.load_i) ? bus.load_data_i : arith_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= RST_VAL;
      state_reg <= RESET;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      state_reg <= cnt_next_state(state_reg, bus.en_i, bus.load_i, bus.up_i, bus.dwn_i);
      ovf_reg   <= arith_ovf;
      unf_reg   <= arith_unf;
    end
  end

  assign bus.count_o = count_reg;
  assign bus.state_o = state_reg;
  assign bus.ovf_o   = ovf_reg;
  assign bus.unf_o   = unf_reg;
  assign bus.tc_o    = ((state_reg == UPCNT)  && (count_reg == {WIDTH{1'b1}})) ||
                       ((state_reg == DWNCNT) && (count_reg == '0));

endmodule

// File: tb/tb_cnt_updown_core.sv
// Drives a wrapping counter and a saturating counter with the same commands.
// Both are checked every cycle against an arithmetic model, and directed steps pin exact values.
module tb_cnt_updown_core;
  import cnt_typedef_pkg::*;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnt_updown_core_if #(.WIDTH(W)) bus_w ();
  cnt_updown_core_if #(.WIDTH(W)) bus_s ();

  cnt_updown_core #(.WIDTH(W), .DUT_SEL(DUT1), .RST_VAL(8'h00)) u_wrap (
    .clk (clk), .rst (rst), .bus (bus_w)
  );
  cnt_updown_core #(.WIDTH(W), .DUT_SEL(DUT2), .RST_VAL(8'h00)) u_sat (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;
  int step_no     = 0;

  // Model: index 0 = wrapping counter, index 1 = saturating counter
  int         m_count [2];
  cnt_state_e m_state [2];
  bit         m_ovf   [2];
  bit         m_unf   [2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, step_no);
    end
  endtask

  function automatic bit model_tc(int v);
    return (m_state[v] == UPCNT && m_count[v] == MAX) || (m_state[v] == DWNCNT && m_count[v] == 0);
  endfunction

  task automatic model_update(bit r, bit e, bit l, bit u, bit d, int data);
    for (int v = 0; v < 2; v++) begin
      m_ovf[v] = 0;
      m_unf[v] = 0;
      if (r) begin
        m_count[v] = 0;
        m_state[v] = RESET;
      end else if (e && l) begin
        m_count[v] = data;
        m_state[v] = LOAD;
      end else if (e && u && !d) begin
        m_state[v] = UPCNT;
        if (m_count[v] == MAX) begin
          m_ovf[v]   = 1;
          m_count[v] = (v == 1) ? MAX : 0;
        end else m_count[v] = m_count[v] + 1;
      end else if (e && d && !u) begin
        m_state[v] = DWNCNT;
        if (m_count[v] == 0) begin
          m_unf[v]   = 1;
          m_count[v] = (v == 1) ? 0 : MAX;
        end else m_count[v] = m_count[v] - 1;
      end else if (e && u && d) begin
        m_state[v] = PREV;
      end else begin
        m_state[v] = (m_state[v] == RESET || m_state[v] == INITIAL) ? INITIAL : PREV;
      end
    end
  endtask

  // Per-cycle compare of both counters against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wrap_count", 32'(bus_w.count_o), 32'(m_count[0]));
      chk("wrap_state", 32'(bus_w.state_o), 32'(m_state[0]));
      chk("wrap_ovf",   32'(bus_w.ovf_o),   32'(m_ovf[0]));
      chk("wrap_unf",   32'(bus_w.unf_o),   32'(m_unf[0]));
      chk("wrap_tc",    32'(bus_w.tc_o),    32'(model_tc(0)));
      chk("sat_count",  32'(bus_s.count_o), 32'(m_count[1]));
      chk("sat_state",  32'(bus_s.state_o), 32'(m_state[1]));
      chk("sat_ovf",    32'(bus_s.ovf_o),   32'(m_ovf[1]));
      chk("sat_unf",    32'(bus_s.unf_o),   32'(m_unf[1]));
      chk("sat_tc",     32'(bus_s.tc_o),    32'(model_tc(1)));
    end
  end

  task automatic step(bit r, bit e, bit l, bit u, bit d, logic [7:0] data);
    rst               = r;
    bus_w.en_i        = e;  bus_s.en_i        = e;
    bus_w.load_i      = l;  bus_s.load_i      = l;
    bus_w.up_i        = u;  bus_s.up_i        = u;
    bus_w.dwn_i       = d;  bus_s.dwn_i       = d;
    bus_w.load_data_i = data;
    bus_s.load_data_i = data;
    @(posedge clk);
    model_update(r, e, l, u, d, int'(data));
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    step_no++;
    $display("step %0d rst=%0b en=%0b ld=%0b up=%0b dn=%0b d=%02h | wrap %02h/%0d sat %02h/%0d",
             step_no, r, e, l, u, d, data, bus_w.count_o, bus_w.state_o,
             bus_s.count_o, bus_s.state_o);
  endtask

  initial begin
    for (int v = 0; v < 2; v++) begin
      m_count[v] = 0; m_state[v] = RESET; m_ovf[v] = 0; m_unf[v] = 0;
    end

    // Reset, then idle
    step(1, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 0, 8'h00);
    chk("rst_state", 32'(bus_w.state_o), 32'(RESET));
    chk("rst_count", 32'(bus_w.count_o), 32'h00);
    chk("rst_tc",    32'(bus_w.tc_o),    32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 8'h00);
      chk("idle_state", 32'(bus_w.state_o), 32'(INITIAL));
      chk("idle_ovf",   32'(bus_w.ovf_o),   32'h0);
    end

    // Load FD, then count up three times with wrap
    step(0, 1, 1, 0, 0, 8'hFD);
    chk("load_fd", 32'(bus_w.count_o), 32'hFD);
    step(0, 1, 0, 1, 0, 8'h00);
    chk("up_fe", 32'(bus_w.count_o), 32'hFE);
    step(0, 1, 0, 1, 0, 8'h00);
    chk("up_ff",    32'(bus_w.count_o), 32'hFF);
    chk("up_ff_tc", 32'(bus_w.tc_o),    32'h1);
    chk("up_ff_ovf", 32'(bus_w.ovf_o),  32'h0);
    step(0, 1, 0, 1, 0, 8'h00);
    chk("wrap_00",     32'(bus_w.count_o), 32'h00);
    chk("wrap_00_ovf", 32'(bus_w.ovf_o),   32'h1);
    chk("sat_ff",      32'(bus_s.count_o), 32'hFF);
    chk("sat_ff_ovf",  32'(bus_s.ovf_o),   32'h1);
    chk("model_ovf",   32'(m_ovf[0]),      32'h1);

    // Saturating decrement through zero
    step(0, 1, 1, 0, 0, 8'h01);
    chk("sat_load01", 32'(bus_s.count_o), 32'h01);
    step(0, 1, 0, 0, 1, 8'h00);
    chk("sat_dn1", 32'(bus_s.count_o), 32'h00);
    chk("sat_dn1_unf", 32'(bus_s.unf_o), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 1, 8'h00);
      chk("sat_dn_cnt",   32'(bus_s.count_o), 32'h00);
      chk("sat_dn_unf",   32'(bus_s.unf_o),   32'h1);
      chk("sat_dn_state", 32'(bus_s.state_o), 32'(DWNCNT));
    end
    chk("wrap_dn_fe", 32'(bus_w.count_o), 32'hFE);
    chk("model_sat", 32'(m_count[1]), 32'h00);

    // Conflicting commands
    step(0, 1, 1, 1, 1, 8'h55);
    chk("conf_load",  32'(bus_w.count_o), 32'h55);
    chk("conf_state", 32'(bus_w.state_o), 32'(LOAD));
    step(0, 1, 0, 1, 1, 8'h00);
    chk("conf_hold",  32'(bus_w.count_o), 32'h55);
    chk("conf_prev",  32'(bus_w.state_o), 32'(PREV));
    chk("conf_flags", 32'({bus_w.ovf_o, bus_w.unf_o}), 32'h0);

    // Reset overrides a count in progress
    step(0, 1, 1, 0, 0, 8'h0F);
    step(0, 1, 0, 1, 0, 8'h00);
    chk("mid_10", 32'(bus_w.count_o), 32'h10);
    step(1, 1, 0, 1, 0, 8'h00);
    chk("mid_rst_cnt",   32'(bus_w.count_o), 32'h00);
    chk("mid_rst_state", 32'(bus_w.state_o), 32'(RESET));
    chk("mid_rst_ovf",   32'(bus_w.ovf_o),   32'h0);
    step(0, 0, 0, 0, 0, 8'h00);
    chk("post_rst_init", 32'(bus_w.state_o), 32'(INITIAL));

    // Commands are ignored while en_i is low
    step(0, 1, 1, 0, 0, 8'h20);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, 8'h00);
      chk("gate_cnt",   32'(bus_w.count_o), 32'h20);
      chk("gate_state", 32'(bus_w.state_o), 32'(PREV));
    end

    // Randomized traffic, biased toward the wrap/saturate boundaries
    for (int i = 0; i < 1500; i++) begin
      bit         r, e, l, u, d;
      logic [7:0] data;
      int         sel;
      r   = ($urandom_range(0, 49) == 0);
      e   = ($urandom_range(0, 7) != 0);
      l   = ($urandom_range(0, 7) == 0);
      u   = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 4);
      case (sel)
        0:       data = 8'h00;
        1:       data = 8'hFF;
        2:       data = 8'h01;
        3:       data = 8'hFE;
        default: data = 8'($urandom);
      endcase
      step(r, e, l, u, d, data);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
